// File: rtl/board_pkg.sv
// ----------------------------------------------------------------------------
// board_pkg
// Shared geometry, colour constants and sweep FSM state type for the game
// board store (board_ctrl) and its row-full reduction (board_row_full).
//
// Contents:
//   ROWS, COLS, CW  - playfield rows (row 0 is the top), columns, colour width
//   ROW_AW, COL_AW  - address widths of the row / column ports
//   COLOR_EMPTY     - colour code of an empty cell
//   row_t           - one packed board row, COLS cells of CW bits
//   state_e         - sweep FSM states
// ----------------------------------------------------------------------------
package board_pkg;

    localparam int unsigned ROWS   = 20;
    localparam int unsigned COLS   = 10;
    localparam int unsigned CW     = 5;
    localparam int unsigned ROW_AW = 5;
    localparam int unsigned COL_AW = 4;

    localparam logic [CW-1:0] COLOR_EMPTY = '0;

    // Cell c of a row lives at [c]; the whole row is COLS*CW bits.
    typedef logic [COLS-1:0][CW-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/board_row_full.sv
// ----------------------------------------------------------------------------
// board_row_full
// Combinational reduction of one board row to a "full" flag: the row is full
// when every one of its COLS cells holds a non-empty colour code.
//
// Ports:
//   i_row   in   COLS*CW  packed row, cell c at bits [c*CW +: CW]
//   o_full  out  1        all cells non-empty
// ----------------------------------------------------------------------------
module board_row_full
    import board_pkg::*;
(
    input  logic [COLS*CW-1:0] i_row,
    output logic               o_full
);

    always_comb begin
        o_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (i_row[c*CW +: CW] == COLOR_EMPTY) begin
                o_full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/board_ctrl.sv
// ----------------------------------------------------------------------------
// board_ctrl
// Game-board store and line-clear engine feeding the VGA map renderer.
// Holds the ROWS x COLS playfield as CW-bit colour codes (0 = empty).
// Game logic writes cells through a valid/ready port; the renderer reads
// through a registered (1-cycle latency) port that is never stalled.
// A clr_start pulse launches a sweep that scans rows bottom-up, removes each
// full row by shifting everything above it down one row, re-checks the same
// row (cascades), and finally pulses clr_done with the number of rows cleared.
//
// Build option:
//   TOTAL_LINES_EN - adds total_lines, a saturating running sum of clr_lines
//                    for the score display.
//
// Ports:
//   CLOCK_50     in   1   system clock
//   RESET_N      in   1   asynchronous active-low reset
//   wr_valid     in   1   cell-write request
//   wr_ready     out  1   high in IDLE; write taken on wr_valid && wr_ready
//   wr_row       in   5   write row (out-of-range writes are taken and dropped)
//   wr_col       in   4   write column
//   wr_color     in   CW  colour code to store
//   rd_row       in   5   renderer read row
//   rd_col       in   4   renderer read column
//   rd_color     out  CW  registered cell contents, 0 when out of range
//   clr_start    in   1   sweep request pulse, ignored while busy
//   busy         out  1   sweep in progress (SCAN, SHIFT, DONE)
//   clr_done     out  1   one-cycle end-of-sweep pulse
//   clr_lines    out  5   rows cleared by the last sweep
//   total_lines  out  16  (TOTAL_LINES_EN only) saturating total of clr_lines
// ----------------------------------------------------------------------------
module board_ctrl
    import board_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ROW_AW-1:0] wr_row,
    input  logic [COL_AW-1:0] wr_col,
    input  logic [CW-1:0]     wr_color,
    input  logic [ROW_AW-1:0] rd_row,
    input  logic [COL_AW-1:0] rd_col,
    output logic [CW-1:0]     rd_color,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic [4:0]        clr_lines
`ifdef TOTAL_LINES_EN
    ,
    output logic [15:0]       total_lines
`endif
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    row_t              r_board [ROWS];
    state_e            r_state;
    state_e            w_state_nxt;
    logic [ROW_AW-1:0] r_scan_row;   // row under test in SCAN
    logic [ROW_AW-1:0] w_scan_row_nxt;
    logic [ROW_AW-1:0] r_shift_row;  // destination row of the current SHIFT step
    logic [ROW_AW-1:0] w_shift_row_nxt;
    logic [4:0]        r_count;      // rows cleared so far in this sweep
    logic [4:0]        w_count_nxt;
    logic [4:0]        r_clr_lines;
    logic [CW-1:0]     r_rd_color;

    logic              w_wr_fire;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_row_full;
    logic              w_enter_done;
    row_t              w_scan_data;

    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_in_range = (wr_row < ROW_AW'(ROWS)) && (wr_col < COL_AW'(COLS));
    assign w_rd_in_range = (rd_row < ROW_AW'(ROWS)) && (rd_col < COL_AW'(COLS));

    // r_scan_row only ever holds ROWS-1 down to 0, so this index is in range.
    assign w_scan_data = r_board[r_scan_row];

    board_row_full u_row_full (
        .i_row  (w_scan_data),
        .o_full (w_row_full)
    );

    // Last row scanned and not full: the sweep ends on the next edge.
    assign w_enter_done = (r_state == SCAN) && !w_row_full && (r_scan_row == '0);

    // ------------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_scan_row  <= '0;
            r_shift_row <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_scan_row  <= w_scan_row_nxt;
            r_shift_row <= w_shift_row_nxt;
            r_count     <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_scan_row_nxt  = r_scan_row;
        w_shift_row_nxt = r_shift_row;
        w_count_nxt     = r_count;

        unique case (r_state)
            IDLE: begin
                if (clr_start) begin
                    w_state_nxt    = SCAN;
                    w_scan_row_nxt = ROW_AW'(ROWS - 1);
                    w_count_nxt    = '0;
                end
            end
            SCAN: begin
                if (w_row_full) begin
                    w_state_nxt     = SHIFT;
                    w_shift_row_nxt = r_scan_row;
                end else if (r_scan_row == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_scan_row_nxt = r_scan_row - ROW_AW'(1);
                end
            end
            SHIFT: begin
                if (r_shift_row == '0) begin
                    // Shift finished; re-scan the same row since the row that
                    // just dropped into it may itself be full.
                    w_state_nxt = SCAN;
                    w_count_nxt = r_count + 5'd1;
                end else begin
                    w_shift_row_nxt = r_shift_row - ROW_AW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Cell array: shifted one row per cycle in SHIFT, written in IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int r = 0; r < ROWS; r++) begin
                r_board[r] <= '0;
            end
        end else if (r_state == SHIFT) begin
            if (r_shift_row == '0) begin
                r_board[0] <= '0;
            end else begin
                r_board[r_shift_row] <= r_board[r_shift_row - ROW_AW'(1)];
            end
        end else if (w_wr_fire && w_wr_in_range) begin
            r_board[wr_row][wr_col] <= wr_color;
        end
    end

    // ------------------------------------------------------------------------
    // Read port and sweep result
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rd_color <= COLOR_EMPTY;
        end else if (w_rd_in_range) begin
            r_rd_color <= r_board[rd_row][rd_col];
        end else begin
            r_rd_color <= COLOR_EMPTY;
        end
    end

    // Latched on entry to DONE so clr_lines is already valid alongside clr_done.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_clr_lines <= '0;
        end else if (w_enter_done) begin
            r_clr_lines <= r_count;
        end
    end

`ifdef TOTAL_LINES_EN
    logic [15:0] r_total_lines;
    logic [16:0] w_total_sum;

    assign w_total_sum = {1'b0, r_total_lines} + 17'(r_count);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_total_lines <= '0;
        end else if (w_enter_done) begin
            r_total_lines <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
        end
    end

    assign total_lines = r_total_lines;
`endif

    assign wr_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign clr_done  = (r_state == DONE);
    assign clr_lines = r_clr_lines;
    assign rd_color  = r_rd_color;

endmodule
